if_fetch_buffer: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC register. Takes the current PC,

---
 rtl/if_fetch_buffer.sv | 121 ++++++++++++
 tb/tb_if_fetch_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: issues PC fetches to instruction memory over a
// req/ack handshake and queues {pc,instr} pairs for the decode stage.
module if_fetch_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [AW-1:0]              pc_i,
  output logic                       pc_stall_o,
  input  logic                       flush_i,
  output logic                       imem_req_o,
  output logic [AW-1:0]              imem_addr_o,
  input  logic                       imem_ack_i,
  input  logic [DW-1:0]              imem_data_i,
  output logic                       id_valid_o,
  output logic [AW-1:0]              id_pc_o,
  output logic [DW-1:0]              id_instr_o,
  input  logic                       id_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_pc_mem    [DEPTH];
  logic [DW-1:0]   r_instr_mem [DEPTH];

  logic            w_kill;
  logic            w_issue;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;

  // Handshake, accept and PC-stall decode from current state and inputs
  always_comb begin
    w_kill      = flush_i | ~start_i;
    w_issue     = (r_state == ST_IDLE) & start_i & ~flush_i & (r_count < CW'(DEPTH));
    imem_req_o  = w_issue | (r_state == ST_REQ) | (r_state == ST_DRAIN);
    imem_addr_o = (r_state == ST_IDLE) ? pc_i : r_addr;
    w_accept    = imem_req_o & imem_ack_i & (r_state != ST_DRAIN) & ~w_kill;
    pc_stall_o  = ~w_kill & ~w_accept;
    w_push      = w_accept;
    w_pop       = id_valid_o & id_ready_i & ~w_kill;
  end

  // Request FSM: one outstanding fetch; a killed fetch is drained until its ack
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_addr <= pc_i;
            if (!imem_ack_i) r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (imem_ack_i)  r_state <= ST_IDLE;
          else if (w_kill) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (imem_ack_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIFO occupancy and pointers; kill empties the queue
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_kill) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // FIFO storage, written with the fetched address and returned instruction
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= imem_addr_o;
      r_instr_mem[r_wr_ptr] <= imem_data_i;
    end
  end

  assign id_valid_o = (r_count != '0);
  assign id_pc_o    = r_pc_mem[r_rd_ptr];
  assign id_instr_o = r_instr_mem[r_rd_ptr];
  assign count_o    = r_count;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer with a PC register model and a
// combinational instruction memory whose data is a function of address.
module tb_if_fetch_buffer;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [31:0] DKEY = 32'hDEAD_0000;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] pc_i;
  logic          pc_stall_o;
  logic          flush_i;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_ack_i;
  logic [DW-1:0] imem_data_i;
  logic          id_valid_o;
  logic [AW-1:0] id_pc_o;
  logic [DW-1:0] id_instr_o;
  logic          id_ready_i;
  logic [1:0]    count_o;
  logic [AW-1:0] tgt;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_buffer #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .pc_stall_o(pc_stall_o), .flush_i(flush_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_instr_o(id_instr_o),
    .id_ready_i(id_ready_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory: data derived from the requested address
  assign imem_data_i = imem_addr_o ^ DKEY;

  // PC register: flush loads target, stop loads 0, otherwise advance unless stalled
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)           pc_i <= '0;
    else if (flush_i)     pc_i <= tgt;
    else if (!start_i)    pc_i <= '0;
    else if (!pc_stall_o) pc_i <= pc_i + 32'd4;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic ack, input logic rdy);
    start_i    = st;
    flush_i    = fl;
    imem_ack_i = ack;
    id_ready_i = rdy;
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 64'(id_valid_o), 64'd1);
    check({tag, "_pc"},    64'(id_pc_o),    64'(pc));
    check({tag, "_instr"}, 64'(id_instr_o), 64'(pc ^ DKEY));
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; imem_ack_i = 1'b0;
    id_ready_i = 1'b0; tgt = '0;

    // Reset state
    tick(); tick();
    check("rst_req",   64'(imem_req_o), 64'd0);
    check("rst_valid", 64'(id_valid_o), 64'd0);
    check("rst_count", 64'(count_o),    64'd0);
    check("rst_pc",    64'(id_pc_o),    64'd0);
    check("rst_instr", 64'(id_instr_o), 64'd0);
    check("rst_stall", 64'(pc_stall_o), 64'd0);
    rst_i = 1'b1;

    // 1: zero-wait memory streams one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      tick(); drive(1, 0, 1, 1);
      check("t1_stall", 64'(pc_stall_o),  64'd0);
      check("t1_addr",  64'(imem_addr_o), 64'(32'(4 * i)));
      if (i > 0) begin
        check_head("t1", 32'(4 * (i - 1)));
        check("t1_count", 64'(count_o), 64'd1);
      end
    end

    // 2: three wait cycles on 0x10; PC held, single push
    for (int k = 0; k < 4; k++) begin
      tick(); drive(1, 0, k == 3, 1);
      check("t2_req",   64'(imem_req_o),  64'd1);
      check("t2_addr",  64'(imem_addr_o), 64'h10);
      check("t2_stall", 64'(pc_stall_o),  64'(k != 3));
      if (k == 0) check_head("t2_prev", 32'hC);
      else        check("t2_valid", 64'(id_valid_o), 64'd0);
    end

    // 3: decode back-pressure fills the FIFO, then drains in order
    tick(); drive(1, 0, 1, 0);
    check_head("t3_h10", 32'h10);
    check("t3_count1", 64'(count_o),     64'd1);
    check("t3_addr14", 64'(imem_addr_o), 64'h14);
    check("t3_stall0", 64'(pc_stall_o),  64'd0);
    for (int k = 0; k < 2; k++) begin
      tick(); drive(1, 0, 1, 0);
      check("t3_full",  64'(count_o),    64'd2);
      check("t3_noreq", 64'(imem_req_o), 64'd0);
      check("t3_stall", 64'(pc_stall_o), 64'd1);
      check("t3_head",  64'(id_pc_o),    64'h10);
    end
    tick(); drive(1, 0, 1, 1);
    check("t3_popreq",   64'(imem_req_o), 64'd0);
    check("t3_popstall", 64'(pc_stall_o), 64'd1);
    check_head("t3_pop10", 32'h10);
    tick(); drive(1, 0, 1, 1);
    check_head("t3_pop14", 32'h14);
    check("t3_addr18", 64'(imem_addr_o), 64'h18);
    check("t3_cnt",    64'(count_o),     64'd1);
    check("t3_st18",   64'(pc_stall_o),  64'd0);
    tick(); drive(1, 0, 1, 1);
    check_head("t3_pop18", 32'h18);
    check("t3_addr1c", 64'(imem_addr_o), 64'h1C);

    // 4: flush during an outstanding request; late ack is drained
    tick(); drive(1, 0, 0, 0);
    check_head("t4_h1c", 32'h1C);
    check("t4_addr20", 64'(imem_addr_o), 64'h20);
    check("t4_stall",  64'(pc_stall_o),  64'd1);
    tick(); tgt = 32'h100; drive(1, 1, 0, 0);
    check("t4_fl_stall", 64'(pc_stall_o),  64'd0);
    check("t4_fl_req",   64'(imem_req_o),  64'd1);
    check("t4_fl_addr",  64'(imem_addr_o), 64'h20);
    check("t4_fl_count", 64'(count_o),     64'd1);
    tick(); drive(1, 0, 0, 0);
    check("t4_dr_count", 64'(count_o),     64'd0);
    check("t4_dr_valid", 64'(id_valid_o),  64'd0);
    check("t4_dr_req",   64'(imem_req_o),  64'd1);
    check("t4_dr_addr",  64'(imem_addr_o), 64'h20);
    check("t4_dr_stall", 64'(pc_stall_o),  64'd1);
    tick(); drive(1, 0, 1, 0);
    check("t4_ack_req",   64'(imem_req_o),  64'd1);
    check("t4_ack_addr",  64'(imem_addr_o), 64'h20);
    check("t4_ack_stall", 64'(pc_stall_o),  64'd1);
    tick(); drive(1, 0, 1, 0);
    check("t4_tgt_addr",  64'(imem_addr_o), 64'h100);
    check("t4_tgt_stall", 64'(pc_stall_o),  64'd0);
    check("t4_tgt_valid", 64'(id_valid_o),  64'd0);

    // 5: flush coincident with ack and a pop; everything discarded
    tick(); drive(1, 0, 0, 0);
    check_head("t5_h100", 32'h100);
    check("t5_addr104", 64'(imem_addr_o), 64'h104);
    check("t5_stall",   64'(pc_stall_o),  64'd1);
    tick(); tgt = 32'h200; drive(1, 1, 1, 1);
    check("t5_fl_stall", 64'(pc_stall_o),  64'd0);
    check("t5_fl_req",   64'(imem_req_o),  64'd1);
    check("t5_fl_addr",  64'(imem_addr_o), 64'h104);
    check("t5_fl_count", 64'(count_o),     64'd1);
    tick(); drive(1, 0, 0, 1);
    check("t5_count", 64'(count_o),     64'd0);
    check("t5_valid", 64'(id_valid_o),  64'd0);
    check("t5_addr",  64'(imem_addr_o), 64'h200);
    check("t5_req",   64'(imem_req_o),  64'd1);
    check("t5_stall", 64'(pc_stall_o),  64'd1);

    // 6: stop mid-request, then async reset while draining
    tick(); drive(0, 0, 0, 1);
    check("t6_stop_stall", 64'(pc_stall_o),  64'd0);
    check("t6_stop_req",   64'(imem_req_o),  64'd1);
    check("t6_stop_addr",  64'(imem_addr_o), 64'h200);
    tick(); drive(0, 0, 0, 1);
    check("t6_drain_req",   64'(imem_req_o),  64'd1);
    check("t6_drain_stall", 64'(pc_stall_o),  64'd0);
    #1; rst_i = 1'b0; #1;
    check("t6_rst_req",   64'(imem_req_o), 64'd0);
    check("t6_rst_valid", 64'(id_valid_o), 64'd0);
    check("t6_rst_count", 64'(count_o),    64'd0);
    check("t6_rst_pc",    64'(id_pc_o),    64'd0);
    check("t6_rst_instr", 64'(id_instr_o), 64'd0);
    check("t6_rst_stall", 64'(pc_stall_o), 64'd0);
    tick(); tick();
    rst_i = 1'b1;
    tick(); drive(1, 0, 1, 1);
    check("t6_re_req",   64'(imem_req_o),  64'd1);
    check("t6_re_addr",  64'(imem_addr_o), 64'd0);
    check("t6_re_stall", 64'(pc_stall_o),  64'd0);
    tick(); drive(1, 0, 1, 1);
    check_head("t6_re_h0", 32'h0);
    check("t6_re_addr4", 64'(imem_addr_o), 64'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
